// File: rtl/cic_pkg.sv
// Shared CIC constants and width helpers, common to the integrator and comb halves.
package cic_pkg;

    localparam int CIC_STAGES     = 3;
    localparam int CIC_DECIMATION = 4;
    localparam int CIC_DIFF_DELAY = 1;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

    // Register growth needed so integrator wrap cancels exactly in the combs.
    function automatic int cic_width(input int in_bits, input int n, input int r, input int m);
        return in_bits + n * clog2(r * m);
    endfunction

endpackage

// File: rtl/cic_comb.sv
// One CIC comb (differentiator) section; the delay line advances only on valid samples.
module cic_comb #(
    parameter int PRECISION  = 12,
    parameter int DIFF_DELAY = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 x_valid,
    input  logic [PRECISION-1:0] x,
    output logic                 y_valid,
    output logic [PRECISION-1:0] y
);

    logic [DIFF_DELAY-1:0][PRECISION-1:0] dly;

    always_ff @(posedge clk) begin
        if (rst) begin
            dly     <= '0;
            y       <= '0;
            y_valid <= 1'b0;
        end else begin
            y_valid <= x_valid;
            if (x_valid) begin
                // Modular subtraction: wrap is intended and cancels integrator wrap.
                y      <= x - dly[DIFF_DELAY-1];
                dly[0] <= x;
                for (int i = 1; i < DIFF_DELAY; i++)
                    dly[i] <= dly[i-1];
            end
        end
    end

endmodule

// File: rtl/cic_decimator_comb.sv
// CIC decimator back end: keeps every DECIMATION-th valid integrator sample and runs
// it through STAGES comb sections at the decimated rate.
module cic_decimator_comb
    import cic_pkg::*;
#(
    parameter int PRECISION  = 12,
    parameter int DECIMATION = CIC_DECIMATION,
    parameter int DIFF_DELAY = CIC_DIFF_DELAY,
    parameter int STAGES     = CIC_STAGES
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 x_valid,
    input  logic [PRECISION-1:0] x,
    output logic [PRECISION-1:0] y,
    output logic                 y_valid
);

    localparam int CNT_W = (clog2(DECIMATION) > 0) ? clog2(DECIMATION) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DECIMATION - 1);

    logic [CNT_W-1:0]                 cnt;
    logic                             keep;
    logic [PRECISION-1:0]             d0;
    logic                             v0;
    logic [STAGES:0][PRECISION-1:0]   stage_data;
    logic [STAGES:0]                  vld_pipe;

    assign keep = x_valid && (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            d0  <= '0;
            v0  <= 1'b0;
        end else begin
            v0 <= keep;
            if (keep)
                d0 <= x;
            if (x_valid)
                cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
        end
    end

    assign stage_data[0] = d0;
    assign vld_pipe[0]   = v0;

    generate
        for (genvar k = 1; k <= STAGES; k++) begin : g_comb
            cic_comb #(
                .PRECISION (PRECISION),
                .DIFF_DELAY(DIFF_DELAY)
            ) u_comb (
                .clk    (clk),
                .rst    (rst),
                .x_valid(vld_pipe[k-1]),
                .x      (stage_data[k-1]),
                .y_valid(vld_pipe[k]),
                .y      (stage_data[k])
            );
        end
    endgenerate

    assign y       = stage_data[STAGES];
    assign y_valid = vld_pipe[STAGES];

endmodule
